// File: rtl/onehot_decoder_4bit.sv
// Buffered 2-to-4 decoder: codes enter a 2-deep FIFO and are replayed
// as registered one-hot patterns, each held for HOLD_CYCLES enabled cycles.
module onehot_decoder_4bit #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] code_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] out,
  output logic       active,
  output logic       done
);

  localparam int CW =
    (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

  typedef enum logic {
    IDLE,
    DRIVE
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_mem [2];
  logic        r_wptr;
  logic        r_rptr;
  logic [1:0]  r_count;
  logic [1:0]  r_code;
  logic [CW-1:0] r_cnt;
  logic [3:0]  r_out;
  logic        r_done;

  logic        w_push;
  logic        w_pop;
  logic        w_nonempty;
  logic [1:0]  w_head;
  logic [1:0]  w_code_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [3:0]  w_out_nxt;
  logic        w_done_nxt;

  assign in_ready   = (r_count != 2'd2) && !rst;
  assign w_push     = in_valid && in_ready;
  assign w_nonempty = (r_count != 2'd0);
  assign w_head     = r_mem[r_rptr];

  assign out    = r_out;
  assign active = (r_state == DRIVE);
  assign done   = r_done;

  // Pops only see the registered count, so a fresh push cannot bypass.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_code_nxt  = r_code;
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = r_out;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_out_nxt = 4'b0000;
        if (w_nonempty && en) begin
          w_pop       = 1'b1;
          w_code_nxt  = w_head;
          w_out_nxt   = 4'b0001 << w_head;
          w_cnt_nxt   = RELOAD;
          w_state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (!en) begin
          w_out_nxt = 4'b0000;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
          w_out_nxt = 4'b0001 << r_code;
        end else begin
          w_done_nxt = 1'b1;
          if (w_nonempty) begin
            w_pop      = 1'b1;
            w_code_nxt = w_head;
            w_out_nxt  = 4'b0001 << w_head;
            w_cnt_nxt  = RELOAD;
          end else begin
            w_out_nxt   = 4'b0000;
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_out_nxt   = 4'b0000;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_code  <= 2'd0;
      r_cnt   <= '0;
      r_out   <= 4'b0000;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_code  <= w_code_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= 2'd0;
      r_mem[1] <= 2'd0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= code_in;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_decoder_4bit.sv
// Directed bench for onehot_decoder_4bit: HOLD_CYCLES=4 instance plus a
// HOLD_CYCLES=1 instance for the single-cycle streaming case.
module tb_onehot_decoder_4bit;

  logic       clk;
  logic       rst;

  logic       a_en;
  logic [1:0] a_code;
  logic       a_valid;
  logic       a_ready;
  logic [3:0] a_out;
  logic       a_active;
  logic       a_done;

  logic       b_en;
  logic [1:0] b_code;
  logic       b_valid;
  logic       b_ready;
  logic [3:0] b_out;
  logic       b_active;
  logic       b_done;

  int checks;
  int errors;
  int ones;

  onehot_decoder_4bit #(.HOLD_CYCLES(4)) dut_a (
    .clk      (clk),
    .rst      (rst),
    .en       (a_en),
    .code_in  (a_code),
    .in_valid (a_valid),
    .in_ready (a_ready),
    .out      (a_out),
    .active   (a_active),
    .done     (a_done)
  );

  onehot_decoder_4bit #(.HOLD_CYCLES(1)) dut_b (
    .clk      (clk),
    .rst      (rst),
    .en       (b_en),
    .code_in  (b_code),
    .in_valid (b_valid),
    .in_ready (b_ready),
    .out      (b_out),
    .active   (b_active),
    .done     (b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [3:0] o,
                       input logic act, input logic dn);
    chk({tag, ".out"}, {4'h0, a_out}, {4'h0, o});
    chk({tag, ".active"}, {7'h0, a_active}, {7'h0, act});
    chk({tag, ".done"}, {7'h0, a_done}, {7'h0, dn});
  endtask

  initial begin
    logic [3:0] seq [3];
    checks = 0;
    errors = 0;
    rst = 1'b1;
    a_en = 1'b1; a_code = 2'd0; a_valid = 1'b0;
    b_en = 1'b1; b_code = 2'd0; b_valid = 1'b0;

    // reset state
    tick();
    chk_a("rst", 4'b0000, 1'b0, 1'b0);
    chk("rst.ready", {7'h0, a_ready}, 8'h0);
    chk("rst.b_out", {4'h0, b_out}, 8'h0);
    rst = 1'b0;
    #1;
    chk("rel.ready", {7'h0, a_ready}, 8'h1);
    tick();

    // single code 2, hold 4
    a_valid = 1'b1; a_code = 2'd2;
    tick();
    a_valid = 1'b0;
    chk_a("t1.push", 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_a("t1.hold", 4'b0100, 1'b1, 1'b0);
    end
    tick();
    chk_a("t1.end", 4'b0000, 1'b0, 1'b1);
    tick();
    chk_a("t1.idle", 4'b0000, 1'b0, 1'b0);

    // back-to-back 3,0,1
    seq[0] = 4'b1000; seq[1] = 4'b0001; seq[2] = 4'b0010;
    a_valid = 1'b1; a_code = 2'd3;
    tick();
    a_code = 2'd0;
    tick();
    for (int i = 0; i < 12; i++) begin
      if (i == 0) a_code = 2'd1;
      if (i == 1) a_valid = 1'b0;
      chk_a("t2.seq", seq[i/4], 1'b1, (i == 4) || (i == 8));
      if (i >= 1 && i <= 3)
        chk("t2.full", {7'h0, a_ready}, 8'h0);
      if (i == 4)
        chk("t2.free", {7'h0, a_ready}, 8'h1);
      tick();
    end
    chk_a("t2.end", 4'b0000, 1'b0, 1'b1);
    tick();

    // en low before and during push of code 1
    a_en = 1'b0; a_valid = 1'b1; a_code = 2'd1;
    tick();
    a_valid = 1'b0;
    chk_a("t3.off0", 4'b0000, 1'b0, 1'b0);
    tick();
    chk_a("t3.off1", 4'b0000, 1'b0, 1'b0);
    tick();
    chk_a("t3.off2", 4'b0000, 1'b0, 1'b0);
    a_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_a("t3.hold", 4'b0010, 1'b1, 1'b0);
    end
    tick();
    chk_a("t3.end", 4'b0000, 1'b0, 1'b1);
    tick();

    // en dropped mid-hold of code 0
    ones = 0;
    a_valid = 1'b1; a_code = 2'd0;
    tick();
    a_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 2) a_en = 1'b0;
      if (i == 4) a_en = 1'b1;
      tick();
      if (a_out == 4'b0001) ones++;
      if (i == 2 || i == 3)
        chk_a("t4.blank", 4'b0000, 1'b1, 1'b0);
      if (i == 4)
        chk_a("t4.resume", 4'b0001, 1'b1, 1'b0);
    end
    chk_a("t4.end", 4'b0000, 1'b0, 1'b1);
    chk("t4.ones", 8'(ones), 8'd4);
    tick();

    // async reset mid-drive with one queued
    a_valid = 1'b1; a_code = 2'd3;
    tick();
    a_code = 2'd2;
    tick();
    a_valid = 1'b0;
    tick();
    chk_a("t5.drv", 4'b1000, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_a("t5.rst", 4'b0000, 1'b0, 1'b0);
    chk("t5.rdy0", {7'h0, a_ready}, 8'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("t5.rdy1", {7'h0, a_ready}, 8'h1);
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (a_out != 4'b0000 || a_active || a_done) ones++;
    end
    chk("t5.stale", 8'(ones), 8'd0);

    // HOLD_CYCLES=1 stream 0,1,2,3
    seq[0] = 4'b0001;
    b_valid = 1'b1; b_code = 2'd0;
    tick();
    b_code = 2'd1;
    tick();
    chk("t6.o0", {4'h0, b_out}, {4'h0, seq[0]});
    chk("t6.d0", {7'h0, b_done}, 8'h0);
    b_code = 2'd2;
    tick();
    chk("t6.o1", {4'h0, b_out}, 8'h02);
    chk("t6.d1", {7'h0, b_done}, 8'h1);
    b_code = 2'd3;
    tick();
    chk("t6.o2", {4'h0, b_out}, 8'h04);
    chk("t6.d2", {7'h0, b_done}, 8'h1);
    b_valid = 1'b0;
    tick();
    chk("t6.o3", {4'h0, b_out}, 8'h08);
    chk("t6.d3", {7'h0, b_done}, 8'h1);
    tick();
    chk("t6.o4", {4'h0, b_out}, 8'h00);
    chk("t6.d4", {7'h0, b_done}, 8'h1);
    chk("t6.act", {7'h0, b_active}, 8'h0);
    tick();
    chk("t6.d5", {7'h0, b_done}, 8'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
